clb_ccff_loader: RTL and testbench
==================================

// Module: clb_ccff_loader
// PURPOSE
//  Word-to-serial configuration loader for the CLB configuration-chain (ccff) shift register.
//  - Accepts configuration words from the bitstream interface and serialises them onto ccff_head.
//  - Drives ccff_en, a clock enable for the chain. Top level gates prog_clk through an ICG with it.
//  - Captures the old chain contents exiting on ccff_tail and returns them as readback words.
//  - Sits between the bitstream host/DMA and the ccff_head/ccff_tail ends of one CLB tile chain.
// PARAMETERS
//  CHAIN_LEN  64  total ccff bits in the chain (>=1)
//  WORD_W     8   cfg/readback word width (>=2)
//  CNT_W      $clog2(CHAIN_LEN+1)  bit-counter width (derived, not overridden)
// PORTS
//  prog_clk   in   1        single clock; all logic rising-edge
//  reset      in   1        synchronous, active-high
//  start      in   1        begin a load; ignored unless state==IDLE
//  cfg_data   in   WORD_W   next configuration word; bit 0 is shifted first
//  cfg_valid  in   1        cfg_data valid
//  cfg_ready  out  1        word accepted when cfg_valid&cfg_ready
//  ccff_head  out  1        serial data into chain (register output)
//  ccff_en    out  1        chain shift enable; chain shifts at each edge where it is 1
//  ccff_tail  in   1        serial data out of chain end
//  rb_data    out  WORD_W   readback word; bit 0 = first bit out of the chain
//  rb_valid   out  1        rb_data valid; held until rb_ready
//  rb_ready   in   1        readback consumer ready
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle pulse when the last readback word is taken
//  bit_count  out  CNT_W    bits shifted so far in the current load
// BEHAVIOUR
//  Reset values: cfg_ready=0, ccff_head=0, ccff_en=0, rb_valid=0, rb_data=0, busy=0, done=0, bit_count=0.
//  FSM states: IDLE, FETCH, SHIFT, FLUSH, DONE.
//  - IDLE -> FETCH on start. Clears bit_count.
//  - FETCH: cfg_ready=1. On handshake, load data shreg <- cfg_data, set n = min(WORD_W, CHAIN_LEN-bit_count), go to SHIFT.
//  - SHIFT lasts exactly n cycles, with ccff_en=1 in every one of them.
//    - ccff_head = shreg[0] in each SHIFT cycle.
//    - At each edge: shreg >>= 1; rb shreg captures ccff_tail into bit position k (k=0..n-1); bit_count++.
//    - ccff_head is driven from a register so it is stable for the whole enabled cycle.
//    - After the n-th bit -> FLUSH.
//  - FLUSH: rb_valid=1, ccff_en=0. The unused high bits of a short final word read back as 0.
//    - On rb_ready: if bit_count==CHAIN_LEN -> DONE, else -> FETCH.
//  - DONE: done=1 for one cycle, then IDLE.
//  - ccff_en is decoded only from the state register (no combinational input path), so the ICG enable is glitch-free.
//  Per-word latency: 1 (accept) + n (shift) + >=1 (readback). Shifting never overlaps a handshake.
//  Boundaries:
//  - cfg_valid low in FETCH: wait indefinitely, ccff_en=0, chain holds.
//  - rb_ready low in FLUSH: stall; no further shifting, so no readback data is lost.
//  - CHAIN_LEN % WORD_W != 0: the last word shifts only the low bits; the upper cfg bits are discarded.
//  - start while busy: ignored. start together with reset: reset wins.
//  - reset mid-load: back to IDLE next edge, ccff_en=0 from the following cycle. Chain contents are undefined (partial load); host must restart.
//  - bit_count never exceeds CHAIN_LEN and wraps to 0 only on the next start.
// STRUCTURE
//  - Shared package clb_cfg_pkg: state enum type (IDLE..DONE), the default WORD_W, and the per-tile CHAIN_LEN constants.
//  - The readback stays inline; no sub-modules are needed.
// TESTING
//  T1 CHAIN_LEN=20, WORD_W=8. Chain model preloaded with 20'hABCDE; words 8'h5A, 8'hC3, 8'hF7.
//     -> ccff_en high for exactly 8+8+4 cycles.
//     -> rb words 8'hDE, 8'hBC, 8'h0A.
//     -> chain ends as 20'h7C35A.
//     -> done pulses once; bit_count=20.
//  T2 Hold cfg_valid=0 for 5 cycles mid-load, then rb_ready=0 for 3 cycles.
//     -> ccff_en=0 throughout both stalls; final chain and readback identical to T1.
//  T3 Assert reset after 11 shifted bits.
//     -> next cycle: busy=0, ccff_en=0, cfg_ready=0, rb_valid=0, bit_count=0.
//     -> a new start then loads correctly.
//  T4 start pulses during SHIFT and FLUSH -> no effect on sequence or bit_count.
//  T5 CHAIN_LEN=64, WORD_W=8, back-to-back loads of pattern P then Q.
//     -> second load's readback == P exactly.
//     -> ccff_en total = 128 cycles.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration-chain loader: FSM state type,
// default word width and the per-tile chain lengths.
package clb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CFG_WORD_W          = 8;
    localparam int CLB_CHAIN_LEN       = 64;
    localparam int CLB_CHAIN_LEN_SMALL = 20;

endpackage

// File: rtl/clb_ccff_loader.sv
// Word-to-serial loader for one CLB ccff chain: serialises config words onto
// ccff_head while capturing the old chain contents from ccff_tail as readback words.
module clb_ccff_loader
    import clb_cfg_pkg::*;
#(
    parameter  int CHAIN_LEN = CLB_CHAIN_LEN,
    parameter  int WORD_W    = CFG_WORD_W,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int IDX_W = $clog2(WORD_W);

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] data_reg;
    logic [WORD_W-1:0] rb_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  last_reg, last_next;
    logic [CNT_W-1:0]  bit_count_reg;
    logic [31:0]       remain;
    logic              accept;
    logic              shifting;

    assign accept   = (state_reg == ST_FETCH) && cfg_valid;
    assign shifting = (state_reg == ST_SHIFT);

    // Index of the last bit to shift for this word: a short final word stops early.
    always_comb begin
        remain = 32'(CHAIN_LEN) - 32'(bit_count_reg);
        if (remain < 32'(WORD_W)) begin
            last_next = IDX_W'(remain - 32'd1);
        end else begin
            last_next = IDX_W'(WORD_W - 1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: if (cfg_valid) state_next = ST_SHIFT;
            ST_SHIFT: if (idx_reg == last_reg) state_next = ST_FLUSH;
            ST_FLUSH: begin
                if (rb_ready) begin
                    state_next = (bit_count_reg == CNT_W'(CHAIN_LEN)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            data_reg      <= '0;
            idx_reg       <= '0;
            last_reg      <= '0;
            bit_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start) begin
                bit_count_reg <= '0;
            end
            if (accept) begin
                data_reg <= cfg_data;
                idx_reg  <= '0;
                last_reg <= last_next;
            end
            if (shifting) begin
                data_reg      <= data_reg >> 1;
                idx_reg       <= idx_reg + 1'b1;
                bit_count_reg <= bit_count_reg + 1'b1;
            end
        end
    end

    // Each readback bit captures the tail only on its own shift slot, so unused
    // high bits of a short word keep the zero written at accept time.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_rb
        always_ff @(posedge prog_clk) begin
            if (reset) begin
                rb_reg[gi] <= 1'b0;
            end else if (accept) begin
                rb_reg[gi] <= 1'b0;
            end else if (shifting && (idx_reg == IDX_W'(gi))) begin
                rb_reg[gi] <= ccff_tail;
            end
        end
    end

    // Chain enable comes purely from the state register to keep the ICG enable glitch-free.
    assign ccff_en   = (state_reg == ST_SHIFT);
    assign ccff_head = data_reg[0];
    assign cfg_ready = (state_reg == ST_FETCH);
    assign rb_valid  = (state_reg == ST_FLUSH);
    assign rb_data   = rb_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_clb_ccff_loader.sv
// Bench for clb_ccff_loader: a 20-bit and a 64-bit chain, each with a behavioural
// shift-register model; readback words are checked by a scoreboard monitor.
module tb_clb_ccff_loader;

    localparam int W    = 8;
    localparam int LEN0 = 20;
    localparam int LEN1 = 64;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic [1:0]        reset, start, cfg_valid, rb_ready;
    logic [1:0]        cfg_ready, head, en, tail, rb_valid, busy, done;
    logic [1:0][7:0]   cfg_data, rb_data;
    logic [1:0][6:0]   bc;
    logic [4:0]        bc0;
    logic [6:0]        bc1;

    assign bc[0] = 7'(bc0);
    assign bc[1] = bc1;

    clb_ccff_loader #(.CHAIN_LEN(LEN0), .WORD_W(W)) dut0 (
        .prog_clk(prog_clk), .reset(reset[0]), .start(start[0]),
        .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
        .ccff_head(head[0]), .ccff_en(en[0]), .ccff_tail(tail[0]),
        .rb_data(rb_data[0]), .rb_valid(rb_valid[0]), .rb_ready(rb_ready[0]),
        .busy(busy[0]), .done(done[0]), .bit_count(bc0)
    );

    clb_ccff_loader #(.CHAIN_LEN(LEN1), .WORD_W(W)) dut1 (
        .prog_clk(prog_clk), .reset(reset[1]), .start(start[1]),
        .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
        .ccff_head(head[1]), .ccff_en(en[1]), .ccff_tail(tail[1]),
        .rb_data(rb_data[1]), .rb_valid(rb_valid[1]), .rb_ready(rb_ready[1]),
        .busy(busy[1]), .done(done[1]), .bit_count(bc1)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Physical chain model: head enters at the top bit, tail is bit 0.
    int          len[2]         = '{LEN0, LEN1};
    logic [63:0] chain[2]       = '{64'd0, 64'd0};
    logic [63:0] preload_val[2] = '{64'd0, 64'd0};
    logic [1:0]  preload        = 2'b00;
    int          en_cnt[2]      = '{0, 0};
    int          done_cnt[2]    = '{0, 0};

    assign tail[0] = chain[0][0];
    assign tail[1] = chain[1][0];

    always @(posedge prog_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload[i]) chain[i] <= preload_val[i];
            else if (en[i]) chain[i] <= (chain[i] >> 1) | (64'(head[i]) << (len[i] - 1));
            if (en[i]) en_cnt[i] <= en_cnt[i] + 1;
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    typedef struct {
        int         idx;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge prog_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rb_valid[i] && rb_ready[i]) begin
                if (exp_q.size() == 0) begin
                    chk("rb_unexpected_word", 64'(rb_data[i]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rb_dut_index", 64'(i), 64'(e.idx));
                    chk("rb_data", 64'(rb_data[i]), 64'(e.d));
                    $display("rb dut%0d word 0x%02h expected 0x%02h", i, rb_data[i], e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    logic [7:0] wbuf[8];

    task automatic do_preload(input int i, input logic [63:0] v);
        preload_val[i] = v;
        preload[i] = 1'b1;
        step();
        preload[i] = 1'b0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
    endtask

    task automatic do_load(input int i, input int stall_word, input int cfg_stall,
                           input int rb_stall, input bit noise);
        int          L, nw, nb, t, en0, d0;
        logic [63:0] old, newc, e64;
        logic [7:0]  wv;
        L = len[i];
        nw = (L + W - 1) / W;
        old = chain[i];
        newc = '0;
        // Readback is the old chain in exit order; the new chain is the words' low bits.
        for (int w = 0; w < nw; w++) begin
            nb = (L - w * W < W) ? (L - w * W) : W;
            e64 = (old >> (w * W)) & ((64'd1 << nb) - 64'd1);
            exp_q.push_back('{idx: i, d: e64[7:0]});
        end
        for (int j = 0; j < L; j++) begin
            wv = wbuf[j / W];
            newc[j] = wv[j % W];
        end
        en0 = en_cnt[i];
        d0  = done_cnt[i];
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        chk("bit_count_cleared", 64'(bc[i]), 64'd0);
        for (int w = 0; w < nw; w++) begin
            t = 0;
            while (!cfg_ready[i] && t < 100) begin step(); t++; end
            chk("cfg_ready_wait", 64'(cfg_ready[i]), 64'd1);
            if (w == stall_word) begin
                for (int c = 0; c < cfg_stall; c++) begin
                    chk("en_fetch_stall", 64'(en[i]), 64'd0);
                    step();
                end
            end
            cfg_data[i] = wbuf[w];
            cfg_valid[i] = 1'b1;
            step();
            cfg_valid[i] = 1'b0;
            cfg_data[i] = 8'($urandom);
            chk("en_after_accept", 64'(en[i]), 64'd1);
            t = 0;
            while (!rb_valid[i] && t < 100) begin
                start[i] = noise;
                step();
                t++;
            end
            start[i] = 1'b0;
            chk("rb_valid_wait", 64'(rb_valid[i]), 64'd1);
            if (w == stall_word) begin
                for (int c = 0; c < rb_stall; c++) begin
                    chk("en_flush_stall", 64'(en[i]), 64'd0);
                    chk("rb_valid_held", 64'(rb_valid[i]), 64'd1);
                    start[i] = noise;
                    step();
                end
            end
            start[i] = 1'b0;
            rb_ready[i] = 1'b1;
            step();
            rb_ready[i] = 1'b0;
        end
        chk("done_pulse", 64'(done[i]), 64'd1);
        step();
        chk("done_one_cycle", 64'(done[i]), 64'd0);
        chk("idle_after_load", 64'(busy[i]), 64'd0);
        chk("bit_count_final", 64'(bc[i]), 64'(L));
        chk("en_cycles", 64'(en_cnt[i] - en0), 64'(L));
        chk("done_count", 64'(done_cnt[i] - d0), 64'd1);
        chk("chain_final", chain[i], newc);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("load dut%0d len %0d chain 0x%0h", i, L, chain[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, e5;
        logic [63:0] pvec, qvec;
        logic [7:0]  wv;
        reset = 2'b11; start = '0; cfg_valid = '0; rb_ready = '0; cfg_data = '0;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_cfg_ready", 64'(cfg_ready[i]), 64'd0);
            chk("rst_head", 64'(head[i]), 64'd0);
            chk("rst_en", 64'(en[i]), 64'd0);
            chk("rst_rb_valid", 64'(rb_valid[i]), 64'd0);
            chk("rst_rb_data", 64'(rb_data[i]), 64'd0);
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_done", 64'(done[i]), 64'd0);
            chk("rst_bit_count", 64'(bc[i]), 64'd0);
        end
        reset = 2'b00;
        step();

        // T1: fixed words into a 20-bit chain preloaded with 0xABCDE
        do_preload(0, 64'hABCDE);
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'hF7;
        do_load(0, -1, 0, 0, 1'b0);
        chk("t1_chain", chain[0], 64'h7C35A);

        // T2: same load with a 5-cycle fetch stall and a 3-cycle readback stall
        do_preload(0, 64'hABCDE);
        do_load(0, 1, 5, 3, 1'b0);
        chk("t2_chain", chain[0], 64'h7C35A);

        // T4: start pulses during SHIFT and FLUSH
        rand_words();
        do_load(0, 2, 2, 2, 1'b1);

        // T3: reset after 11 shifted bits, start held with it
        do_preload(0, 64'({$urandom, $urandom}) & 64'hFFFFF);
        rand_words();
        exp_q.push_back('{idx: 0, d: chain[0][7:0]});
        start[0] = 1'b1; step(); start[0] = 1'b0;
        t = 0;
        while (!cfg_ready[0] && t < 100) begin step(); t++; end
        cfg_data[0] = wbuf[0]; cfg_valid[0] = 1'b1; step(); cfg_valid[0] = 1'b0;
        t = 0;
        while (!rb_valid[0] && t < 100) begin step(); t++; end
        chk("t3_rb_valid_wait", 64'(rb_valid[0]), 64'd1);
        rb_ready[0] = 1'b1; step(); rb_ready[0] = 1'b0;
        t = 0;
        while (!cfg_ready[0] && t < 100) begin step(); t++; end
        cfg_data[0] = wbuf[1]; cfg_valid[0] = 1'b1; step(); cfg_valid[0] = 1'b0;
        repeat (3) step();
        chk("t3_bits_before_reset", 64'(bc[0]), 64'd11);
        chk("t3_en_before_reset", 64'(en[0]), 64'd1);
        reset[0] = 1'b1; start[0] = 1'b1;
        step();
        reset[0] = 1'b0; start[0] = 1'b0;
        chk("t3_busy", 64'(busy[0]), 64'd0);
        chk("t3_en", 64'(en[0]), 64'd0);
        chk("t3_cfg_ready", 64'(cfg_ready[0]), 64'd0);
        chk("t3_rb_valid", 64'(rb_valid[0]), 64'd0);
        chk("t3_bit_count", 64'(bc[0]), 64'd0);
        step();
        chk("t3_start_with_reset_ignored", 64'(busy[0]), 64'd0);
        rand_words();
        do_load(0, -1, 0, 0, 1'b0);

        // Randomised loads with random stalls and start noise
        repeat (4) begin
            rand_words();
            do_load(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        // T5: 64-bit chain, back-to-back loads of P then Q
        do_preload(1, {$urandom, $urandom});
        rand_words();
        pvec = '0;
        for (int k = 0; k < 8; k++) begin wv = wbuf[k]; pvec[k*8 +: 8] = wv; end
        e5 = en_cnt[1];
        do_load(1, int'($urandom_range(0, 7)), 2, 2, 1'b0);
        chk("t5_chain_is_p", chain[1], pvec);
        rand_words();
        qvec = '0;
        for (int k = 0; k < 8; k++) begin wv = wbuf[k]; qvec[k*8 +: 8] = wv; end
        do_load(1, -1, 0, 0, 1'b0);
        chk("t5_chain_is_q", chain[1], qvec);
        chk("t5_en_total", 64'(en_cnt[1] - e5), 64'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
